// File: rtl/otter_mem_pkg.sv
// Shared definitions for the OTTER data-port initiator: access sizes,
// IO boundary and the load/store unit state encoding.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    localparam logic [31:0] IO_BASE = 32'h0001_0000;

    typedef enum logic [3:0] {
        IDLE,
        ERR,
        LD,
        LD_LO,
        LD_HI,
        LD_WAIT,
        ST,
        ST_BYTE,
        RESP
    } lsu_state_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/otter_lsu_align.sv
// Extracts a byte/half/word from a 64-bit {hi, lo} window at a byte offset
// and zero- or sign-extends it to 32 bits.
module otter_lsu_align
    import otter_mem_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [31:0] win;

    // Shift the window down to the requested byte, then size and extend.
    always_comb begin
        win  = 32'({hi, lo} >> {off, 3'b000});
        data = win;
        case (size)
            SZ_BYTE: data = sign ? {24'd0, win[7:0]}  : {{24{win[7]}}, win[7:0]};
            SZ_HALF: data = sign ? {16'd0, win[15:0]} : {{16{win[15]}}, win[15:0]};
            default: data = win;
        endcase
    end

endmodule

// File: rtl/otter_lsu.sv
// Load/store unit driving the OTTER memory data port. Misaligned loads are
// split into two aligned word reads, misaligned stores into byte writes;
// misaligned accesses that reach into IO space are rejected.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request
// ERR     | one-cycle error response, no memory activity
// LD      | aligned read issued (RDEN2 high)
// LD_LO   | split load: read of the lower aligned word
// LD_HI   | split load: read of the upper word, lower word captured
// LD_WAIT | read data captured into the response register
// ST      | aligned write issued (WE2 high)
// ST_BYTE | split store: one byte write per cycle
// RESP    | one-cycle completion pulse
module otter_lsu
    import otter_mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    lsu_state_t  state_q, state_d;
    logic        accept;

    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        sign_q, split_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lo_q;

    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_sign;
    logic        misaligned, req_err;
    logic [32:0] last_byte;
    logic [1:0]  last_idx;
    logic [31:0] word_base, split_data;

    logic        rden_d, we_d, sign_d, rsp_valid_d, rsp_err_d;
    logic [31:0] addr_d, din_d, rdata_d;
    logic [1:0]  size_d;

    assign REQ_READY = (state_q == IDLE);
    assign accept    = REQ_VALID && REQ_READY;

    // Outputs for the first access cycle are registered at the accept edge,
    // so the live request is used then and the latched copy afterwards.
    assign cur_addr  = accept ? REQ_ADDR  : addr_q;
    assign cur_wdata = accept ? REQ_WDATA : wdata_q;
    assign cur_size  = accept ? REQ_SIZE  : size_q;
    assign cur_sign  = accept ? REQ_SIGN  : sign_q;

    assign misaligned = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                        ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
    // Highest byte touched, one bit wider so a wrap past 4 GiB still counts as IO.
    assign last_byte  = {1'b0, cur_addr} + {30'd0, size_bytes(cur_size)} - 33'd1;
    assign req_err    = (cur_size == 2'd3) ||
                        (misaligned && (last_byte >= {1'b0, IO_BASE}));

    assign last_idx  = (size_q == SZ_WORD) ? 2'd3 : 2'd1;
    assign word_base = {cur_addr[31:2], 2'b00};

    otter_lsu_align u_align (
        .hi   (MEM_DOUT2),
        .lo   (lo_q),
        .off  (addr_q[1:0]),
        .size (size_q),
        .sign (sign_q),
        .data (split_data)
    );

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rden_d      = 1'b0;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = 32'd0;
        addr_d      = MEM_ADDR2;
        din_d       = MEM_DIN2;
        size_d      = MEM_SIZE;
        sign_d      = MEM_SIGN;

        case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                if (REQ_VALID) begin
                    if (req_err)
                        state_d = ERR;
                    else if (REQ_WE)
                        state_d = misaligned ? ST_BYTE : ST;
                    else
                        state_d = misaligned ? LD_LO : LD;
                end
            end
            ERR:     state_d = IDLE;
            LD:      state_d = LD_WAIT;
            LD_LO:   state_d = LD_HI;
            LD_HI:   state_d = LD_WAIT;
            LD_WAIT: state_d = RESP;
            ST:      state_d = RESP;
            ST_BYTE: begin
                if (cnt_q == last_idx)
                    state_d = RESP;
                else
                    cnt_d = cnt_q + 2'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            LD: begin
                rden_d = 1'b1;
                addr_d = cur_addr;
                size_d = cur_size;
                sign_d = cur_sign;
            end
            LD_LO: begin
                rden_d = 1'b1;
                addr_d = word_base;
                size_d = SZ_WORD;
                sign_d = cur_sign;
            end
            LD_HI: begin
                rden_d = 1'b1;
                addr_d = word_base + 32'd4;
                size_d = SZ_WORD;
            end
            ST: begin
                we_d   = 1'b1;
                addr_d = cur_addr;
                size_d = cur_size;
                sign_d = cur_sign;
                din_d  = cur_wdata;
            end
            ST_BYTE: begin
                we_d   = 1'b1;
                addr_d = cur_addr + {30'd0, cnt_d};
                size_d = SZ_BYTE;
                din_d  = {24'd0, cur_wdata[{cnt_d, 3'b000} +: 8]};
            end
            ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                if (state_q == LD_WAIT)
                    rdata_d = split_q ? split_data : MEM_DOUT2;
            end
            default: ;
        endcase
    end

    // State, byte counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            MEM_RDEN2 <= 1'b0;
            MEM_WE2   <= 1'b0;
            MEM_ADDR2 <= 32'd0;
            MEM_DIN2  <= 32'd0;
            MEM_SIZE  <= 2'd0;
            MEM_SIGN  <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            MEM_RDEN2 <= rden_d;
            MEM_WE2   <= we_d;
            MEM_ADDR2 <= addr_d;
            MEM_DIN2  <= din_d;
            MEM_SIZE  <= size_d;
            MEM_SIGN  <= sign_d;
            RSP_VALID <= rsp_valid_d;
            RSP_ERR   <= rsp_err_d;
            RSP_RDATA <= rdata_d;
        end
    end

    // Request latch at accept and capture of the lower word of a split load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            split_q <= 1'b0;
            lo_q    <= 32'd0;
        end else begin
            if (accept) begin
                addr_q  <= REQ_ADDR;
                wdata_q <= REQ_WDATA;
                size_q  <= REQ_SIZE;
                sign_q  <= REQ_SIGN;
                split_q <= misaligned;
            end
            if (state_q == LD_HI)
                lo_q <= MEM_DOUT2;
        end
    end

endmodule

// File: tb/tb_otter_lsu.sv
// Bench for otter_lsu: a byte-array memory on the data port, a reference
// model that predicts every cycle of each transaction from the request alone,
// and a single negedge compare process.
module tb_otter_lsu;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [31:0] REQ_ADDR = 32'd0;
    logic [1:0]  REQ_SIZE = 2'd0;
    logic        REQ_SIGN = 1'b0;
    logic [31:0] REQ_WDATA = 32'd0;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        MEM_RDEN2;
    logic        MEM_WE2;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    localparam logic [31:0] IO_B = otter_mem_pkg::IO_BASE;

    otter_lsu dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    bit [7:0] env_mem [int unsigned];
    bit [7:0] ref_mem [int unsigned];
    logic [31:0] rd_word = 32'd0;
    logic [31:0] dout_win;

    typedef struct {
        bit          rden;
        bit          wen;
        bit          cm;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          cs;
        bit          sign;
        logic [31:0] din;
        logic [31:0] dmask;
        bit          rsp;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t expq[$];
    exp_t cur_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic bit [7:0] env_byte(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 8'h00;
    endfunction

    function automatic bit [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] env_word(input logic [31:0] a);
        return {env_byte(a + 3), env_byte(a + 2), env_byte(a + 1), env_byte(a)};
    endfunction

    // Memory on port 2: sized writes and a registered word read.
    always @(posedge CLK) begin
        if (MEM_WE2) begin
            env_mem[MEM_ADDR2] = MEM_DIN2[7:0];
            if (MEM_SIZE != 2'd0) env_mem[MEM_ADDR2 + 1] = MEM_DIN2[15:8];
            if (MEM_SIZE == 2'd2) begin
                env_mem[MEM_ADDR2 + 2] = MEM_DIN2[23:16];
                env_mem[MEM_ADDR2 + 3] = MEM_DIN2[31:24];
            end
        end
        if (MEM_RDEN2) rd_word <= env_word({MEM_ADDR2[31:2], 2'b00});
    end

    // Sized read data off the registered word and the current address/size.
    always_comb begin
        dout_win = rd_word >> {MEM_ADDR2[1:0], 3'b000};
        case (MEM_SIZE)
            2'd0:    MEM_DOUT2 = MEM_SIGN ? {24'd0, dout_win[7:0]}  : {{24{dout_win[7]}}, dout_win[7:0]};
            2'd1:    MEM_DOUT2 = MEM_SIGN ? {16'd0, dout_win[15:0]} : {{16{dout_win[15]}}, dout_win[15:0]};
            default: MEM_DOUT2 = dout_win;
        endcase
    end

    function automatic exp_t mk(input bit rden, input bit wen, input bit cm,
                                input logic [31:0] addr, input logic [1:0] size,
                                input bit cs, input bit sign,
                                input logic [31:0] din, input logic [31:0] dmask,
                                input bit rsp, input bit err, input logic [31:0] rdata);
        exp_t e;
        e.rden = rden; e.wen = wen; e.cm = cm; e.addr = addr; e.size = size;
        e.cs = cs; e.sign = sign; e.din = din; e.dmask = dmask;
        e.rsp = rsp; e.err = err; e.rdata = rdata;
        return e;
    endfunction

    // Per-cycle compare against the model's expectation queue.
    always @(negedge CLK) begin
        if (chk_en) begin
            if (expq.size() > 0) begin
                cur_e = expq.pop_front();
                chk("ready_busy", {31'd0, REQ_READY}, 32'd0);
                chk("rden", {31'd0, MEM_RDEN2}, {31'd0, cur_e.rden});
                chk("we", {31'd0, MEM_WE2}, {31'd0, cur_e.wen});
                chk("rsp_valid", {31'd0, RSP_VALID}, {31'd0, cur_e.rsp});
                if (cur_e.cm) begin
                    chk("mem_addr", MEM_ADDR2, cur_e.addr);
                    chk("mem_size", {30'd0, MEM_SIZE}, {30'd0, cur_e.size});
                end
                if (cur_e.cs) chk("mem_sign", {31'd0, MEM_SIGN}, {31'd0, cur_e.sign});
                if (cur_e.dmask != 32'd0) chk("mem_din", MEM_DIN2 & cur_e.dmask, cur_e.din & cur_e.dmask);
                if (cur_e.rsp) begin
                    chk("rsp_err", {31'd0, RSP_ERR}, {31'd0, cur_e.err});
                    chk("rsp_rdata", RSP_RDATA, cur_e.rdata);
                end
            end else begin
                chk("ready_idle", {31'd0, REQ_READY}, 32'd1);
                chk("rden_idle", {31'd0, MEM_RDEN2}, 32'd0);
                chk("we_idle", {31'd0, MEM_WE2}, 32'd0);
                chk("rsp_idle", {31'd0, RSP_VALID}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge CLK);
            n++;
        end
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, REQ_READY}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, RSP_VALID}, 32'd0);
        chk({tag, "_rsp_rdata"}, RSP_RDATA, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, RSP_ERR}, 32'd0);
        chk({tag, "_rden"}, {31'd0, MEM_RDEN2}, 32'd0);
        chk({tag, "_we"}, {31'd0, MEM_WE2}, 32'd0);
        chk({tag, "_addr"}, MEM_ADDR2, 32'd0);
        chk({tag, "_din"}, MEM_DIN2, 32'd0);
        chk({tag, "_size"}, {30'd0, MEM_SIZE}, 32'd0);
        chk({tag, "_sign"}, {31'd0, MEM_SIGN}, 32'd0);
    endtask

    task automatic preload();
        logic [63:0] init;
        init = 64'h8877_6655_4433_2211;
        env_mem.delete();
        ref_mem.delete();
        for (int i = 0; i < 8; i++) begin
            env_mem[32'h100 + i] = init[8*i +: 8];
            ref_mem[32'h100 + i] = init[8*i +: 8];
        end
    endtask

    // Drive one request and queue the cycle-by-cycle behaviour it must cause.
    task automatic issue(input bit we, input logic [31:0] a, input logic [1:0] sz,
                         input bit sgn, input logic [31:0] wd,
                         input bit has_lit, input logic [31:0] lit, input string nm);
        int nb;
        bit mis, err;
        longint last;
        logic [31:0] res, base;
        wait_idle();
        @(negedge CLK); #1;
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_SIZE = sz;
        REQ_SIGN = sgn; REQ_WDATA = wd;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;

        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis  = (a % nb) != 0;
        last = longint'(a) + nb - 1;
        err  = (sz == 2'd3) || (mis && last >= longint'(IO_B));
        res  = 32'd0;
        if (!err && !we) begin
            for (int i = 0; i < nb; i++) res |= 32'(ref_byte(a + i)) << (8 * i);
            if (!sgn && nb < 4 && res[8*nb-1]) res |= 32'hFFFF_FFFF << (8 * nb);
        end

        if (err) begin
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd0));
        end else if (!we && !mis) begin
            expq.push_back(mk(1, 0, 1, a, sz, 1, sgn, 0, 0, 0, 0, 0));
            expq.push_back(mk(0, 0, 1, a, sz, 1, sgn, 0, 0, 0, 0, 0));
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, res));
        end else if (!we) begin
            base = a & ~32'd3;
            expq.push_back(mk(1, 0, 1, base, 2'd2, 0, 0, 0, 0, 0, 0, 0));
            expq.push_back(mk(1, 0, 1, base + 4, 2'd2, 0, 0, 0, 0, 0, 0, 0));
            expq.push_back(mk(0, 0, 1, base + 4, 2'd2, 0, 0, 0, 0, 0, 0, 0));
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, res));
        end else begin
            if (!mis)
                expq.push_back(mk(0, 1, 1, a, sz, 0, 0, wd, 32'hFFFF_FFFF, 0, 0, 0));
            else
                for (int k = 0; k < nb; k++)
                    expq.push_back(mk(0, 1, 1, a + k, 2'd0, 0, 0, {24'd0, wd[8*k +: 8]}, 32'h0000_00FF, 0, 0, 0));
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0));
            for (int k = 0; k < nb; k++) ref_mem[a + k] = wd[8*k +: 8];
        end
        if (has_lit) chk({"model_", nm}, res, lit);
    endtask

    initial begin
        preload();
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        @(negedge CLK); #1;
        RST = 1'b0;
        chk_en = 1'b1;

        // aligned and split loads
        issue(0, 32'h100, 2'd2, 0, 0, 1, 32'h4433_2211, "lw_100");
        issue(0, 32'h102, 2'd2, 0, 0, 1, 32'h6655_4433, "lw_102");
        issue(0, 32'h103, 2'd1, 0, 0, 1, 32'h0000_5544, "lh_103");
        issue(0, 32'h107, 2'd0, 0, 0, 1, 32'hFFFF_FF88, "lb_107");
        issue(0, 32'h107, 2'd0, 1, 0, 1, 32'h0000_0088, "lbu_107");
        issue(0, 32'h106, 2'd1, 0, 0, 1, 32'hFFFF_8877, "lh_106");
        issue(0, 32'h106, 2'd1, 1, 0, 1, 32'h0000_8877, "lhu_106");
        issue(0, 32'h101, 2'd1, 0, 0, 1, 32'h0000_3322, "lh_101");
        issue(0, 32'h103, 2'd2, 0, 0, 1, 32'h7766_5544, "lw_103");
        issue(0, 32'h105, 2'd1, 1, 0, 1, 32'h0000_7766, "lhu_105");

        // split store and readback
        issue(1, 32'h101, 2'd2, 0, 32'h1234_5678, 0, 0, "sw_101");
        wait_idle();
        chk("mem_100_after_sw", env_word(32'h100), 32'h3456_7811);
        chk("mem_104_after_sw", env_word(32'h104), 32'h8877_6612);
        issue(0, 32'h100, 2'd2, 0, 0, 1, 32'h3456_7811, "rd_100");
        issue(0, 32'h104, 2'd2, 0, 0, 1, 32'h8877_6612, "rd_104");

        // aligned stores
        issue(1, 32'h106, 2'd1, 0, 32'h1111_CAFE, 0, 0, "sh_106");
        issue(0, 32'h104, 2'd2, 0, 0, 1, 32'hCAFE_6612, "rd_104b");
        issue(1, 32'h100, 2'd0, 0, 32'h0000_00A5, 0, 0, "sb_100");
        issue(0, 32'h100, 2'd0, 1, 0, 1, 32'h0000_00A5, "lbu_100");

        // aligned IO pass-through
        issue(0, 32'h0001_0000, 2'd2, 0, 0, 1, 32'h0, "lw_io");
        issue(1, 32'h0001_0004, 2'd2, 0, 32'hDEAD_BEEF, 0, 0, "sw_io");
        issue(0, 32'h0001_0004, 2'd2, 0, 0, 1, 32'hDEAD_BEEF, "lw_io_rb");

        // errors and the IO boundary
        issue(0, 32'h0001_0002, 2'd2, 0, 0, 1, 32'h0, "err_lw_io");
        issue(0, 32'h100, 2'd3, 0, 0, 1, 32'h0, "err_size3");
        issue(1, 32'h0000_FFFE, 2'd2, 0, 32'h5555_5555, 0, 0, "err_sw_cross");
        issue(0, 32'h0000_FFFF, 2'd1, 0, 0, 1, 32'h0, "err_lh_cross");
        issue(0, 32'h0000_FFFD, 2'd1, 0, 0, 1, 32'h0, "lh_below_io");
        issue(0, 32'h0000_FFFC, 2'd2, 0, 0, 1, 32'h0, "lw_below_io");
        wait_idle();
        chk("mem_err_untouched", env_word(32'h0000_FFFC), 32'h0);

        // reset in the middle of a split half store
        preload();
        wait_idle();
        @(negedge CLK); #1;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h103; REQ_SIZE = 2'd1;
        REQ_SIGN = 1'b0; REQ_WDATA = 32'h0000_BEEF;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        expq.push_back(mk(0, 1, 1, 32'h103, 2'd0, 0, 0, 32'h0000_00EF, 32'h0000_00FF, 0, 0, 0));
        ref_mem[32'h103] = 8'hEF;
        #2;
        RST = 1'b1;
        @(posedge CLK); #1;
        check_zero("mid_rst");
        @(negedge CLK); #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("mem_100_after_rst", env_word(32'h100), 32'hEF33_2211);
        chk("mem_104_after_rst", env_word(32'h104), 32'h8877_6655);
        issue(0, 32'h100, 2'd2, 0, 0, 1, 32'hEF33_2211, "rd_100_rst");
        issue(0, 32'h104, 2'd2, 0, 0, 1, 32'h8877_6655, "rd_104_rst");

        wait_idle();
        repeat (3) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
